// File: rtl/bev_brew_sequencer.sv
// Brew-cycle sequencer: drink-code lookup, tick-timed press/heat/deliver phases,
// sensor-drop abort with refund, and a progressive delivery LED bar.
module bev_brew_sequencer #(
  parameter int SEL_W        = 4,
  parameter int N_DRINKS     = 4,
  parameter logic [N_DRINKS*SEL_W-1:0] VALID_CODES = {4'b1111, 4'b1010, 4'b0101, 4'b0000},
  parameter int SENSOR_W     = 3,
  parameter int TICK_DIV     = 50000000,
  parameter int PRESS_TICKS  = 3,
  parameter int HEAT_TICKS   = 2,
  parameter int LED_W        = 10,
  parameter int STEP_TICKS   = 1,
  parameter int REFUND_TICKS = 2,
  localparam int IDX_W = (N_DRINKS > 1) ? $clog2(N_DRINKS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [SENSOR_W-1:0] sensors,
  input  logic                coin_ok,
  input  logic                btn,
  input  logic [SEL_W-1:0]    sel,
  output logic [IDX_W-1:0]    drink_idx,
  output logic                armed,
  output logic                pressurizing,
  output logic                heating,
  output logic [LED_W-1:0]    led_bar,
  output logic                refund,
  output logic                err_sel,
  output logic                err_abort,
  output logic                done
);

  localparam int HEAT_MAX = HEAT_TICKS * N_DRINKS;
  localparam int M0    = (PRESS_TICKS > HEAT_MAX) ? PRESS_TICKS : HEAT_MAX;
  localparam int M1    = (STEP_TICKS > REFUND_TICKS) ? STEP_TICKS : REFUND_TICKS;
  localparam int T_MAX = (M0 > M1) ? M0 : M1;
  localparam int T_W   = $clog2(T_MAX + 1);
  localparam int D_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [2:0] {
    IDLE, ARMED, PRESS, HEAT, DELIVER, DONE, REFUND
  } state_t;

  state_t           state, state_nxt;
  logic [D_W-1:0]   div_cnt;
  logic [T_W-1:0]   tcnt, tcnt_inc, heat_lim;
  logic [2:0]       btn_pipe;
  logic             tick, ready, abort, btn_rise;
  logic             hit, load_idx, set_sel, set_abort, step;
  logic [IDX_W-1:0] hit_idx;

  assign ready    = (&sensors) & coin_ok;
  assign abort    = ~(&sensors);
  assign btn_rise = btn_pipe[1] & ~btn_pipe[2];
  assign tick     = (div_cnt == D_W'(TICK_DIV - 1));
  assign tcnt_inc = tcnt + 1'b1;
  assign heat_lim = T_W'(HEAT_TICKS * (int'(drink_idx) + 1));

  // Descending scan so the lowest matching table entry wins.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int k = N_DRINKS - 1; k >= 0; k--) begin
      if (sel == VALID_CODES[k*SEL_W +: SEL_W]) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(k);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    load_idx  = 1'b0;
    set_sel   = 1'b0;
    set_abort = 1'b0;
    step      = 1'b0;
    case (state)
      IDLE:   if (ready) state_nxt = ARMED;
      ARMED: begin
        if (!ready) state_nxt = IDLE;
        else if (btn_rise) begin
          if (hit) begin
            state_nxt = PRESS;
            load_idx  = 1'b1;
          end else begin
            state_nxt = REFUND;
            set_sel   = 1'b1;
          end
        end
      end
      PRESS: begin
        if (abort) begin
          state_nxt = REFUND;
          set_abort = 1'b1;
        end else if (tick && tcnt_inc == T_W'(PRESS_TICKS)) state_nxt = HEAT;
      end
      HEAT: begin
        if (abort) begin
          state_nxt = REFUND;
          set_abort = 1'b1;
        end else if (tick && tcnt_inc == heat_lim) state_nxt = DELIVER;
      end
      DELIVER: begin
        if (abort) begin
          state_nxt = REFUND;
          set_abort = 1'b1;
        end else if (tick && tcnt_inc == T_W'(STEP_TICKS)) begin
          if (&led_bar) state_nxt = DONE;
          else          step      = 1'b1;
        end
      end
      DONE:   state_nxt = IDLE;
      REFUND: if (tick && tcnt_inc == T_W'(REFUND_TICKS)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign armed        = (state == ARMED);
  assign pressurizing = (state == PRESS);
  assign heating      = (state == HEAT);
  assign refund       = (state == REFUND);
  assign done         = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      div_cnt   <= '0;
      tcnt      <= '0;
      btn_pipe  <= '0;
      drink_idx <= '0;
      led_bar   <= '0;
      err_sel   <= 1'b0;
      err_abort <= 1'b0;
    end else begin
      state    <= state_nxt;
      btn_pipe <= {btn_pipe[1:0], btn};
      // Divider and tick timer restart on every state change; a bar step restarts the timer only.
      if (state_nxt != state) begin
        div_cnt <= '0;
        tcnt    <= '0;
      end else if (tick) begin
        div_cnt <= '0;
        tcnt    <= step ? '0 : tcnt_inc;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
      if (load_idx) begin
        drink_idx <= hit_idx;
        err_sel   <= 1'b0;
        err_abort <= 1'b0;
      end else if (set_sel) begin
        err_sel   <= 1'b1;
        err_abort <= 1'b0;
      end else if (set_abort) begin
        err_sel   <= 1'b0;
        err_abort <= 1'b1;
      end
      if (state_nxt == DELIVER && state != DELIVER) led_bar <= LED_W'(1);
      else if (step)                                led_bar <= {led_bar[LED_W-2:0], 1'b1};
      else if (set_abort || state_nxt == DONE)      led_bar <= '0;
    end
  end

endmodule

// File: tb/tb_bev_brew_sequencer.sv
// Bench for bev_brew_sequencer: phase/countdown reference model compared every cycle,
// directed scenarios with literal expectations, then randomized stimulus.
module tb_bev_brew_sequencer;

  localparam int TD = 4, PRESS_T = 2, HEAT_T = 3, LED_N = 4, STEP_T = 1, REF_T = 2;
  localparam int P_IDLE = 0, P_ARMED = 1, P_PRESS = 2, P_HEAT = 3, P_DELIVER = 4,
                 P_DONE = 5, P_REFUND = 6;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic [2:0] sensors = 3'b111;
  logic       coin_ok = 1'b0, btn = 1'b0;
  logic [3:0] sel = 4'b0000;
  logic [1:0] drink_idx;
  logic       armed, pressurizing, heating, refund, err_sel, err_abort, done;
  logic [3:0] led_bar;

  bev_brew_sequencer #(
    .TICK_DIV(TD), .PRESS_TICKS(PRESS_T), .HEAT_TICKS(HEAT_T), .LED_W(LED_N),
    .STEP_TICKS(STEP_T), .REFUND_TICKS(REF_T)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sensors(sensors), .coin_ok(coin_ok), .btn(btn), .sel(sel),
    .drink_idx(drink_idx), .armed(armed), .pressurizing(pressurizing), .heating(heating),
    .led_bar(led_bar), .refund(refund), .err_sel(err_sel), .err_abort(err_abort), .done(done)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: each phase is a countdown in clock cycles.
  int   codes[4] = '{0, 5, 10, 15};
  int   m_phase, m_left, m_idx, m_led, m_es, m_ea, m_f;
  bit   m_rise, m_rdy, m_ab;
  logic [2:0] bh;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = P_IDLE; m_left = 0; m_idx = 0; m_led = 0; m_es = 0; m_ea = 0; bh = 3'b000;
    end else begin
      m_rise = bh[1] & ~bh[2];
      m_rdy  = (sensors == 3'b111) && coin_ok;
      m_ab   = (sensors != 3'b111);
      case (m_phase)
        P_IDLE: if (m_rdy) m_phase = P_ARMED;
        P_ARMED: begin
          if (!m_rdy) m_phase = P_IDLE;
          else if (m_rise) begin
            m_f = -1;
            for (int k = 3; k >= 0; k--) if (int'(sel) == codes[k]) m_f = k;
            if (m_f >= 0) begin
              m_idx = m_f; m_es = 0; m_ea = 0; m_phase = P_PRESS; m_left = PRESS_T * TD;
            end else begin
              m_es = 1; m_ea = 0; m_phase = P_REFUND; m_left = REF_T * TD;
            end
          end
        end
        P_PRESS, P_HEAT, P_DELIVER: begin
          if (m_ab) begin
            m_phase = P_REFUND; m_left = REF_T * TD; m_ea = 1; m_es = 0; m_led = 0;
          end else begin
            m_left--;
            if (m_left == 0) begin
              if (m_phase == P_PRESS) begin
                m_phase = P_HEAT; m_left = HEAT_T * (m_idx + 1) * TD;
              end else if (m_phase == P_HEAT) begin
                m_phase = P_DELIVER; m_led = 1; m_left = LED_N * STEP_T * TD;
              end else begin
                m_phase = P_DONE; m_led = 0;
              end
            end else if (m_phase == P_DELIVER) begin
              m_led = (1 << ((LED_N * STEP_T * TD - m_left) / (STEP_T * TD) + 1)) - 1;
            end
          end
        end
        P_DONE: m_phase = P_IDLE;
        P_REFUND: begin
          m_left--;
          if (m_left == 0) m_phase = P_IDLE;
        end
        default: m_phase = P_IDLE;
      endcase
      bh = {bh[1:0], btn};
    end
  end

  logic [14:0] act_v, exp_v;
  always @(negedge clk) begin
    act_v = {drink_idx, armed, pressurizing, heating, led_bar, refund, err_sel, err_abort, done};
    exp_v = {m_idx[1:0], m_phase == P_ARMED, m_phase == P_PRESS, m_phase == P_HEAT, m_led[3:0],
             m_phase == P_REFUND, m_es[0], m_ea[0], m_phase == P_DONE};
    chk("cycle", int'(act_v), int'(exp_v));
  end

  // Activity counters sampled from the DUT; snapshots are taken while the counted signal is idle.
  int cnt_press = 0, cnt_heat = 0, cnt_refund = 0, cnt_done = 0, cnt_armed = 0, press_starts = 0;
  logic prev_press = 1'b0;
  always @(negedge clk) begin
    cnt_press  += int'(pressurizing);
    cnt_heat   += int'(heating);
    cnt_refund += int'(refund);
    cnt_done   += int'(done);
    cnt_armed  += int'(armed);
    if (pressurizing && !prev_press) press_starts++;
    prev_press = pressurizing;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_phase(input int p, input int budget, input string nm);
    int c = 0;
    while (m_phase != p && c < budget) begin
      @(negedge clk);
      c++;
    end
    if (m_phase != p) chk(nm, m_phase, p);
  endtask

  task automatic pulse_btn();
    btn = 1'b1;
    tick(3);
    btn = 1'b0;
  endtask

  int s_press, s_heat, s_ref, s_done, s_arm, s_starts;
  task automatic snap();
    s_press = cnt_press; s_heat = cnt_heat; s_ref = cnt_refund;
    s_done = cnt_done; s_arm = cnt_armed; s_starts = press_starts;
  endtask

  initial begin
    tick(3);
    chk("reset_outputs", int'({drink_idx, armed, pressurizing, heating, led_bar, refund,
                               err_sel, err_abort, done}), 0);
    rst_n = 1'b1;

    // 1: valid code 0101 -> idx 1, full brew
    coin_ok = 1'b1; sel = 4'b0101;
    wait_phase(P_ARMED, 10, "t1_armed");
    snap();
    pulse_btn();
    wait_phase(P_PRESS, 10, "t1_press");
    chk("t1_drink_idx", drink_idx, 1);
    wait_phase(P_DONE, 100, "t1_done");
    tick(2);
    chk("t1_press_cycles", cnt_press - s_press, 8);
    chk("t1_heat_cycles", cnt_heat - s_heat, 24);
    chk("t1_done_pulses", cnt_done - s_done, 1);

    // 2: invalid code -> err_sel and refund
    sel = 4'b0011;
    wait_phase(P_ARMED, 10, "t2_armed");
    snap();
    pulse_btn();
    wait_phase(P_REFUND, 10, "t2_refund");
    chk("t2_err_sel", err_sel, 1);
    wait_phase(P_IDLE, 20, "t2_idle");
    chk("t2_refund_cycles", cnt_refund - s_ref, 8);
    chk("t2_no_press", cnt_press - s_press, 0);

    // 3: sensor drop at cycle 10 of HEAT
    sel = 4'b1111;
    wait_phase(P_ARMED, 10, "t3_armed");
    snap();
    pulse_btn();
    wait_phase(P_HEAT, 20, "t3_heat");
    tick(9);
    sensors = 3'b101;
    tick(1);
    chk("t3_heating_off", heating, 0);
    chk("t3_refund_on", refund, 1);
    sensors = 3'b111;
    wait_phase(P_IDLE, 20, "t3_idle");
    chk("t3_err_abort", err_abort, 1);
    chk("t3_refund_cycles", cnt_refund - s_ref, 8);
    chk("t3_no_done", cnt_done - s_done, 0);

    // 4: held button starts one brew; no coin keeps IDLE
    sel = 4'b1010;
    wait_phase(P_ARMED, 10, "t4_armed");
    snap();
    btn = 1'b1;
    tick(100);
    btn = 1'b0;
    wait_phase(P_ARMED, 100, "t4_rearmed");
    tick(5);
    chk("t4_one_brew", press_starts - s_starts, 1);
    coin_ok = 1'b0;
    wait_phase(P_IDLE, 10, "t4_idle");
    snap();
    pulse_btn();
    tick(6);
    chk("t4_no_arm", cnt_armed - s_arm, 0);
    chk("t4_no_brew", press_starts - s_starts, 0);

    // 5: reset while led_bar = 0011
    coin_ok = 1'b1; sel = 4'b0101;
    wait_phase(P_ARMED, 10, "t5_armed");
    pulse_btn();
    wait_phase(P_DELIVER, 100, "t5_deliver");
    tick(4);
    chk("t5_led_0011", led_bar, 4'b0011);
    #2 rst_n = 1'b0;
    #1 chk("t5_reset_outputs", int'({drink_idx, armed, pressurizing, heating, led_bar, refund,
                                     err_sel, err_abort, done}), 0);
    tick(2);
    rst_n = 1'b1;
    tick(1);
    chk("t5_rearm", armed, 1);

    // 6: sel change during HEAT has no effect
    sel = 4'b1111;
    wait_phase(P_ARMED, 10, "t6_armed");
    snap();
    pulse_btn();
    wait_phase(P_HEAT, 20, "t6_heat");
    sel = 4'b0000;
    wait_phase(P_DELIVER, 100, "t6_deliver");
    chk("t6_drink_idx", drink_idx, 3);
    chk("t6_heat_cycles", cnt_heat - s_heat, 48);

    // Randomized traffic, checked cycle by cycle against the model
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      sensors = ($urandom_range(0, 99) < 2) ? 3'($urandom_range(0, 7)) :
                (sensors != 3'b111 && $urandom_range(0, 3) != 0) ? sensors : 3'b111;
      if ($urandom_range(0, 49) == 0) coin_ok = ~coin_ok;
      else if (!coin_ok && $urandom_range(0, 9) == 0) coin_ok = 1'b1;
      if ($urandom_range(0, 7) == 0) btn = ~btn;
      if ($urandom_range(0, 5) == 0)
        sel = ($urandom_range(0, 9) < 7) ? 4'(codes[$urandom_range(0, 3)]) : 4'($urandom_range(0, 15));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bev_brew_sequencer.md
Name: bev_brew_sequencer

Overview:
Parametrised brew-cycle controller for the coffee machine. It replaces the fixed pressurize/heat/deliver chain with a sequencer driven by a table of valid drink codes. Heating time scales with the selected drink. Payment and interlock sensors gate every brew, a sensor drop aborts the brew with a refund, and the delivery LED bar fills progressively. It sits between the sensor/selection switches and the display/RGB/LED decoders.

Parameters:
SEL_W, 4, width of drink-selection code
N_DRINKS, 4, number of valid drink codes
VALID_CODES, {4'b1111,4'b1010,4'b0101,4'b0000}, N_DRINKS*SEL_W packed table; entry k at bits [k*SEL_W +: SEL_W]
SENSOR_W, 3, number of interlock sensors (all must be 1 to brew)
TICK_DIV, 50000000, clk cycles per timing tick
PRESS_TICKS, 3, pressurization duration in ticks
HEAT_TICKS, 2, base heat duration; actual = HEAT_TICKS*(drink_idx+1)
LED_W, 10, delivery bar width
STEP_TICKS, 1, ticks per delivery bar step
REFUND_TICKS, 2, refund indication duration in ticks

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
sensors  in  SENSOR_W  interlock sensors (water, cup, lid); active high
coin_ok  in  1  payment present, level
btn  in  1  start button, active high, asynchronous level
sel  in  SEL_W  drink selection switches
drink_idx  out  clog2(N_DRINKS)  index of the accepted drink
armed  out  1  ready for selection
pressurizing  out  1  PRESS state
heating  out  1  HEAT state
led_bar  out  LED_W  delivery progress, thermometer code
refund  out  1  money-return indicator
err_sel  out  1  last rejection was an invalid code (sticky until next armed->brew)
err_abort  out  1  last rejection was a sensor drop (sticky until next armed->brew)
done  out  1  one-cycle pulse at the end of a successful brew

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0; divider, timers and synchronizers are cleared.
- btn passes through a 2-flop synchronizer followed by a rising-edge detector, giving btn_rise as a 1-cycle pulse. A held button produces exactly one pulse.
- ready = (&sensors) & coin_ok.
- Tick divider: a counter restarts at 0 on every state transition. tick=1 when the counter reaches TICK_DIV-1, and the counter then wraps. A state lasting N ticks is therefore held for exactly N*TICK_DIV cycles.
- State IDLE: go to ARMED when ready=1.
- State ARMED (armed=1): if ready=0, go to IDLE. On btn_rise, sel is compared against all VALID_CODES.
  - On a match, drink_idx <= lowest matching k, err_sel and err_abort are cleared, and the state goes to PRESS.
  - On no match, err_sel is set and the state goes to REFUND.
- State PRESS (pressurizing=1): after PRESS_TICKS ticks, go to HEAT.
- State HEAT (heating=1): after HEAT_TICKS*(drink_idx+1) ticks, go to DELIVER. Timer width must hold HEAT_TICKS*N_DRINKS without overflow.
- State DELIVER: led_bar=1 on entry. Every STEP_TICKS ticks, led_bar <= {led_bar[LED_W-2:0],1'b1}. When led_bar is all ones and STEP_TICKS further ticks elapse, go to DONE. Total duration is LED_W*STEP_TICKS ticks.
- State DONE: done=1 for one cycle and led_bar cleared, then go to IDLE.
- State REFUND (refund=1): after REFUND_TICKS ticks, go to IDLE.
- Abort: in PRESS, HEAT or DELIVER, any sensors bit at 0 causes the next state to be REFUND, err_abort=1 and led_bar cleared. coin_ok is ignored once brewing has started.
- Simultaneous events: an abort takes priority over timer expiry in the same cycle. In ARMED, ready dropping takes priority over btn_rise. btn_rise outside ARMED is discarded.
- sel is sampled only at the accepting cycle; later changes have no effect on drink_idx.
- Reset asserted mid-brew forces IDLE immediately and clears all outputs, with no refund pulse.

Test Plan:
Common settings: TICK_DIV=4, PRESS_TICKS=2, HEAT_TICKS=3, LED_W=4, STEP_TICKS=1, REFUND_TICKS=2.
1. ready=1, sel=4'b0101, pulse btn -> drink_idx=1; pressurizing for 8 cycles; heating for 24 cycles; led_bar steps 0001, 0011, 0111, 1111 at 4 cycles each; done pulses once; state returns to IDLE.
2. sel=4'b0011, pulse btn in ARMED -> err_sel=1; refund=1 for 8 cycles; pressurizing never asserted.
3. sel=4'b1111 (idx 3), drop sensors[1] at cycle 10 of HEAT -> next cycle heating=0, refund=1 for 8 cycles, err_abort=1, done never asserted.
4. btn held high for 100 cycles in ARMED -> exactly one brew starts. A btn press with coin_ok=0 -> stays in IDLE with no state change.
5. Assert rst_n=0 while led_bar=0011 -> all outputs 0 immediately. After release with ready=1 -> ARMED within 1 cycle.
6. Change sel during HEAT -> drink_idx and heat duration unchanged.
